// File: rtl/frame_readout_buffer_pkg.sv
// Shared definitions for the frame readout buffer: address-map offsets,
// status-byte layout and overflow policy encodings.
package frame_readout_buffer_pkg;

  localparam int OFS_DROP_CNT    = 3;
  localparam int OFS_HEAD_STATUS = 2;
  localparam int OFS_STATUS      = 1;

  typedef enum logic {
    OVF_DROP_NEWEST = 1'b0,
    OVF_DROP_OLDEST = 1'b1
  } ovf_policy_e;

  typedef struct packed {
    logic       overflow;
    logic       empty;
    logic [1:0] rsvd;
    logic [3:0] level;
  } status_byte_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_readout_buffer_frame_fifo.sv
// Register-based frame FIFO with level tracking and the choice between
// refusing a new frame or evicting the oldest when full.
module frame_fifo
  import frame_readout_buffer_pkg::*;
#(
  parameter int W         = 100,
  parameter int DEPTH     = 4,
  parameter int LW        = 4,
  parameter int OVERWRITE = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_wr;
  logic          evict;
  logic          adv_rd;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign do_pop = rd_en & ~empty;
  // A full FIFO only takes a frame if a slot frees up this cycle
  assign evict  = wr_en & full & ~do_pop
                & (OVERWRITE == int'(OVF_DROP_OLDEST));
  assign do_wr  = wr_en & (~full | do_pop | evict);
  assign adv_rd = do_pop | evict;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (adv_rd)
        rd_ptr <= rd_ptr + PW'(1);
      if (do_wr && !adv_rd)
        level <= level + LW'(1);
      else if (adv_rd && !do_wr)
        level <= level - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/frame_readout_buffer.sv
// Frame FIFO front end for the MCU: pop/clear edge detection, overflow
// and drop-count registers, and the byte-wide read mux.
module frame_readout_buffer
  import frame_readout_buffer_pkg::*;
#(
  parameter int FRAME_BYTES = 12,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int OVERWRITE   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [FRAME_BYTES*8-1:0] frame_data,
  input  logic [3:0]               frame_status,
  input  logic                     frame_valid,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic                     pop,
  input  logic                     clear,
  output logic [7:0]               parallel_out,
  output logic                     valid,
  output logic                     overflow
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int EW = FW + 4;
  localparam int A  = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ADR_DROP =
    ADDR_WIDTH'(A - OFS_DROP_CNT);
  localparam logic [ADDR_WIDTH-1:0] ADR_HSTAT =
    ADDR_WIDTH'(A - OFS_HEAD_STATUS);
  localparam logic [ADDR_WIDTH-1:0] ADR_STATUS =
    ADDR_WIDTH'(A - OFS_STATUS);

  logic                  pop_q;
  logic                  clear_q;
  logic                  pop_edge;
  logic                  clear_edge;
  logic                  loss;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] level;
  logic [EW-1:0]         head;
  logic [FW-1:0]         head_frame;
  logic [3:0]            head_status;
  logic [7:0]            drop_cnt;
  logic [7:0]            frame_byte;
  logic                  in_frame;
  status_byte_t          st;

  assign pop_edge   = pop & ~pop_q;
  assign clear_edge = clear & ~clear_q;
  // A pop on a full FIFO always makes room, so only an unpopped full write loses
  assign loss       = frame_valid & full & ~pop_edge;

  frame_fifo #(
    .W         (EW),
    .DEPTH     (DEPTH),
    .LW        (ADDR_WIDTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (frame_valid),
    .wr_data ({frame_status, frame_data}),
    .rd_en   (pop_edge),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign head_frame  = head[FW-1:0];
  assign head_status = head[EW-1:FW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pop_q    <= 1'b1;
      clear_q  <= 1'b1;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pop_q   <= pop;
      clear_q <= clear;
      if (loss) begin
        overflow <= 1'b1;
        drop_cnt <= clear_edge ? 8'd1 : sat_inc(drop_cnt);
      end else if (clear_edge) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  assign valid = ~empty;

  always_comb begin
    st.overflow = overflow;
    st.empty    = empty;
    st.rsvd     = 2'b00;
    st.level    = 4'(level);
  end

  always_comb begin
    frame_byte = 8'h00;
    in_frame   = 1'b0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (address == ADDR_WIDTH'(k)) begin
        in_frame   = 1'b1;
        frame_byte = head_frame[8*k +: 8];
      end
    end
  end

  always_comb begin
    parallel_out = 8'h00;
    unique case (1'b1)
      in_frame:
        parallel_out = empty ? 8'h00 : frame_byte;
      (address == ADR_DROP):
        parallel_out = drop_cnt;
      (address == ADR_HSTAT):
        parallel_out = {4'h0, empty ? 4'h0 : head_status};
      (address == ADR_STATUS):
        parallel_out = st;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_readout_buffer.sv
// Bench for frame_readout_buffer: both overflow policies side by side,
// checked against a queue model of the frame FIFO.
module tb_frame_readout_buffer;

  localparam int FB = 12;
  localparam int D  = 4;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [FB*8-1:0] frame_data;
  logic [3:0]    frame_status;
  logic          frame_valid;
  logic [AW-1:0] address;
  logic          pop;
  logic          clear;
  logic [7:0]    po [2];
  logic          vld [2];
  logic          ovf [2];

  always #10 clock = ~clock;

  frame_readout_buffer #(
    .FRAME_BYTES(FB), .DEPTH(D), .ADDR_WIDTH(AW), .OVERWRITE(0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .frame_data(frame_data),
    .frame_status(frame_status), .frame_valid(frame_valid),
    .address(address), .pop(pop), .clear(clear),
    .parallel_out(po[0]), .valid(vld[0]), .overflow(ovf[0])
  );

  frame_readout_buffer #(
    .FRAME_BYTES(FB), .DEPTH(D), .ADDR_WIDTH(AW), .OVERWRITE(1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .frame_data(frame_data),
    .frame_status(frame_status), .frame_valid(frame_valid),
    .address(address), .pop(pop), .clear(clear),
    .parallel_out(po[1]), .valid(vld[1]), .overflow(ovf[1])
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  int n_vec;
  int n_bad;
  int q [2][$];
  int m_drop [2];
  bit m_ovf [2];
  bit pop_prev;
  bit clr_prev;
  rd_vec_t tbl [6];

  function automatic logic [FB*8-1:0] frame_of(input int n);
    logic [FB*8-1:0] f;
    for (int k = 0; k < FB; k++) f[8*k +: 8] = 8'(n * 16 + k);
    return f;
  endfunction

  function automatic logic [3:0] status_of(input int n);
    return 4'(n) ^ 4'hE;
  endfunction

  task automatic chk(input string name, input int d,
                     input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %02h expected %02h", name, d, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a,
                    output logic [7:0] v0, output logic [7:0] v1);
    address = a;
    #1;
    v0 = po[0];
    v1 = po[1];
  endtask

  task automatic check_all(input string tag);
    logic [7:0] st [2];
    logic [7:0] dr [2];
    logic [7:0] hs [2];
    logic [7:0] b0 [2];
    logic [7:0] bl [2];
    logic [FB*8-1:0] f;
    logic [3:0] s;
    int sz;
    rd(4'd15, st[0], st[1]);
    rd(4'd13, dr[0], dr[1]);
    rd(4'd14, hs[0], hs[1]);
    rd(4'd0,  b0[0], b0[1]);
    rd(4'd11, bl[0], bl[1]);
    for (int d = 0; d < 2; d++) begin
      sz = q[d].size();
      f = (sz > 0) ? frame_of(q[d][0]) : '0;
      s = (sz > 0) ? status_of(q[d][0]) : 4'h0;
      chk({tag, " status"}, d, st[d], {m_ovf[d], sz == 0, 2'b00, 4'(sz)});
      chk({tag, " drops"}, d, dr[d], 8'(m_drop[d]));
      chk({tag, " hstat"}, d, hs[d], {4'h0, s});
      chk({tag, " byte0"}, d, b0[d], f[7:0]);
      chk({tag, " byte11"}, d, bl[d], f[FB*8-1 -: 8]);
      chk({tag, " valid"}, d, {7'b0, vld[d]}, {7'b0, sz > 0});
      chk({tag, " ovf"}, d, {7'b0, ovf[d]}, {7'b0, m_ovf[d]});
    end
  endtask

  task automatic step(input bit fv, input int id,
                      input bit popv, input bit clr, input string tag);
    bit pe;
    bit ce;
    bit lost;
    int sz;
    frame_valid  = fv;
    frame_data   = frame_of(id);
    frame_status = status_of(id);
    pop          = popv;
    clear        = clr;
    @(posedge clock);
    #1;
    frame_valid = 1'b0;
    pe = popv & ~pop_prev;
    ce = clr & ~clr_prev;
    for (int d = 0; d < 2; d++) begin
      sz = q[d].size();
      lost = 1'b0;
      if (pe && sz > 0) void'(q[d].pop_front());
      if (fv) begin
        if (sz == D && !pe) begin
          lost = 1'b1;
          if (d == 1) begin
            void'(q[d].pop_front());
            q[d].push_back(id);
          end
        end else begin
          q[d].push_back(id);
        end
      end
      if (lost) begin
        m_ovf[d]  = 1'b1;
        m_drop[d] = ce ? 1 : ((m_drop[d] < 255) ? m_drop[d] + 1 : 255);
      end else if (ce) begin
        m_ovf[d]  = 1'b0;
        m_drop[d] = 0;
      end
    end
    pop_prev = popv;
    clr_prev = clr;
    check_all(tag);
  endtask

  task automatic pop_one();
    step(1'b0, 0, 1'b1, 1'b0, "pop_hi");
    step(1'b0, 0, 1'b0, 1'b0, "pop_lo");
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      m_drop[d] = 0;
      m_ovf[d]  = 1'b0;
    end
    pop_prev = 1'b1;
    clr_prev = 1'b1;
  endtask

  initial begin
    logic [7:0] v0;
    logic [7:0] v1;
    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{4'd0,  8'h10};
    tbl[1] = '{4'd11, 8'h1B};
    tbl[2] = '{4'd14, 8'h0F};
    tbl[3] = '{4'd15, 8'h01};
    tbl[4] = '{4'd12, 8'h00};
    tbl[5] = '{4'd13, 8'h00};

    reset        = 1'b0;
    pop          = 1'b1;
    clear        = 1'b1;
    frame_valid  = 1'b0;
    frame_data   = '0;
    frame_status = '0;
    address      = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all("in_reset");
    reset = 1'b1;
    step(1'b0, 0, 1'b1, 1'b1, "rel_hi");
    step(1'b0, 0, 1'b1, 1'b1, "rel_hi2");
    step(1'b0, 0, 1'b0, 1'b0, "idle");

    step(1'b1, 1, 1'b0, 1'b0, "push1");
    for (int i = 0; i < 6; i++) begin
      rd(tbl[i].addr, v0, v1);
      chk($sformatf("tbl%0d", i), 0, v0, tbl[i].exp);
      chk($sformatf("tbl%0d", i), 1, v1, tbl[i].exp);
    end

    for (int n = 2; n <= 5; n++) step(1'b1, n, 1'b0, 1'b0, "fill5");
    rd(4'd15, v0, v1);
    chk("full_status", 0, v0, 8'h84);
    chk("full_status", 1, v1, 8'h84);
    rd(4'd13, v0, v1);
    chk("one_drop", 0, v0, 8'h01);
    chk("one_drop", 1, v1, 8'h01);
    rd(4'd0, v0, v1);
    chk("keep_oldest", 0, v0, 8'h10);
    chk("keep_newest", 1, v1, 8'h20);
    repeat (4) pop_one();

    step(1'b0, 0, 1'b0, 1'b1, "clear");
    step(1'b0, 0, 1'b0, 1'b0, "clear_lo");
    for (int n = 6; n <= 9; n++) step(1'b1, n, 1'b0, 1'b0, "fill4");
    step(1'b1, 10, 1'b1, 1'b0, "full_pushpop");
    rd(4'd15, v0, v1);
    chk("full_pushpop_lvl", 0, v0, 8'h04);
    chk("full_pushpop_lvl", 1, v1, 8'h04);
    step(1'b0, 0, 1'b0, 1'b0, "pop_lo");
    repeat (4) pop_one();

    step(1'b1, 11, 1'b1, 1'b0, "empty_pushpop");
    rd(4'd15, v0, v1);
    chk("empty_pushpop_lvl", 0, v0, 8'h01);
    chk("empty_pushpop_lvl", 1, v1, 8'h01);
    rd(4'd0, v0, v1);
    chk("empty_pushpop_head", 0, v0, 8'hB0);
    chk("empty_pushpop_head", 1, v1, 8'hB0);
    step(1'b0, 0, 1'b0, 1'b0, "pop_lo");
    pop_one();

    for (int n = 12; n <= 15; n++) step(1'b1, n, 1'b0, 1'b0, "refill");
    for (int n = 0; n < 300; n++) step(1'b1, 100 + n, 1'b0, 1'b0, "drops");
    rd(4'd13, v0, v1);
    chk("drop_sat", 0, v0, 8'hFF);
    chk("drop_sat", 1, v1, 8'hFF);
    step(1'b0, 0, 1'b0, 1'b1, "clear_sat");
    rd(4'd13, v0, v1);
    chk("drop_cleared", 0, v0, 8'h00);
    chk("drop_cleared", 1, v1, 8'h00);
    step(1'b0, 0, 1'b0, 1'b0, "clear_lo");
    step(1'b1, 500, 1'b0, 1'b1, "clear_vs_loss");
    rd(4'd13, v0, v1);
    chk("clear_vs_loss_cnt", 0, v0, 8'h01);
    chk("clear_vs_loss_cnt", 1, v1, 8'h01);
    step(1'b0, 0, 1'b0, 1'b0, "clear_lo");
    repeat (2) pop_one();

    @(posedge clock);
    #3 reset = 1'b0;
    model_reset();
    rd(4'd15, v0, v1);
    chk("async_reset", 0, v0, 8'h40);
    chk("async_reset", 1, v1, 8'h40);
    chk("async_reset_valid", 0, {7'b0, vld[0]}, 8'h00);
    chk("async_reset_valid", 1, {7'b0, vld[1]}, 8'h00);
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0, "post_reset");
    step(1'b1, 7, 1'b0, 1'b0, "post_reset_push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
